// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the control sequencer: FSM state encoding,
// legal control codes, the reset code and the code legality check.
package ctrl_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] CODE_ENABLE  = 4'b0001;
  localparam logic [3:0] CODE_DISABLE = 4'b0010;
  localparam logic [3:0] CODE_LOCK    = 4'b0011;
  localparam logic [3:0] CODE_RESET   = CODE_DISABLE;

  function automatic logic code_is_valid(input logic [3:0] code);
    return (code == CODE_ENABLE) || (code == CODE_DISABLE) || (code == CODE_LOCK);
  endfunction

endpackage

// File: rtl/ctrl_code_decode.sv
// Pure combinational decode of the registered control code into the
// enable_all / lock_on strobes; any other code decodes to false/false.
module ctrl_code_decode
  import ctrl_seq_pkg::*;
(
  input  logic [3:0] i_code,
  output logic       o_enable_all,
  output logic       o_lock_on
);

  // Code to strobe decode
  always_comb begin
    o_enable_all = 1'b0;
    o_lock_on    = 1'b0;
    case (i_code)
      CODE_ENABLE: o_enable_all = 1'b1;
      CODE_LOCK:   o_lock_on    = 1'b1;
      default: begin
        o_enable_all = 1'b0;
        o_lock_on    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Command-driven control code sequencer with settle delay and sticky lock.
// Optional rejected-command counter enabled by macro CTRL_SEQ_ERR_CNT_EN.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_code,
  output logic       cmd_ready,
  output logic       resp_valid,
  output logic       resp_err,
  input  logic       resp_ready,
  output logic [3:0] control_signal,
  output logic       enable_all,
  output logic       lock_on,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_code;
  logic [3:0] r_ctrl;
  logic [3:0] r_settle_cnt;
  logic       r_resp_err;
  logic       w_accept;
  logic       w_reject;
  logic       w_noop;
  logic       w_enable_all;
  logic       w_lock_on;

  ctrl_code_decode u_decode (
    .i_code       (r_ctrl),
    .o_enable_all (w_enable_all),
    .o_lock_on    (w_lock_on)
  );

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  // APPLY is the single evaluation cycle for every accepted command; the lock
  // is sampled from the live control code, which cannot change before APPLY.
  assign w_reject = !code_is_valid(r_code) || w_lock_on;
  assign w_noop   = (r_code == r_ctrl);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_next_state = ST_APPLY;
        else           w_next_state = ST_IDLE;
      end
      ST_APPLY: begin
        if (w_reject || w_noop) w_next_state = ST_RESP;
        else                    w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt <= 4'd1) w_next_state = ST_RESP;
        else                      w_next_state = ST_SETTLE;
      end
      ST_RESP: begin
        if (resp_ready) w_next_state = ST_IDLE;
        else            w_next_state = ST_RESP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Command capture, control code, settle counter and response status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code       <= 4'd0;
      r_ctrl       <= CODE_RESET;
      r_settle_cnt <= 4'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_code <= cmd_code;
          r_resp_err <= 1'b0;
        end
        ST_APPLY: begin
          r_resp_err <= w_reject;
          if (!w_reject && !w_noop) begin
            r_ctrl       <= r_code;
            r_settle_cnt <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt != 4'd0) r_settle_cnt <= r_settle_cnt - 4'd1;
        end
        ST_RESP: begin
          if (resp_ready) r_resp_err <= 1'b0;
        end
        default: begin
          r_settle_cnt <= 4'd0;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CTRL_SEQ_ERR_CNT_EN
  logic [7:0] r_err_count;

  // Saturating count of rejected commands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if ((r_state == ST_APPLY) && w_reject && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign cmd_ready      = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign resp_valid     = (r_state == ST_RESP);
  assign resp_err       = r_resp_err;
  assign control_signal = r_ctrl;
  assign enable_all     = w_enable_all;
  assign lock_on        = w_lock_on;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles control_signal is held stable after a change before a response is issued; legal range 1..15.
REQ-002 Port clk input 1: single clock; all state updates on its rising edge.
REQ-003 Port rst input 1: reset, asynchronous and active-high.
REQ-004 Port cmd_valid input 1: a command is presented on cmd_code.
REQ-005 Port cmd_code input 4: requested control code.
REQ-006 Port cmd_ready output 1: the sequencer can accept a command.
REQ-007 Port resp_valid output 1: a command result is available.
REQ-008 Port resp_err output 1: the result is a rejection; valid only while resp_valid=1.
REQ-009 Port resp_ready input 1: the requester consumes the result.
REQ-010 Port control_signal output 4: registered control code driven to the enable datapath.
REQ-011 Port enable_all output 1: decoded from control_signal; 1 only when control_signal=0001.
REQ-012 Port lock_on output 1: decoded from control_signal; 1 only when control_signal=0011.
REQ-013 Port busy output 1: the FSM is not in IDLE.
REQ-014 Port err_count output 8: number of rejected commands.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, APPLY, SETTLE and RESP.
REQ-016 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on a cycle where cmd_valid=1 and cmd_ready=1.
REQ-017 Valid codes SHALL be 0001 (enable), 0010 (disable) and 0011 (lock); every other code is invalid.
REQ-018 An accepted invalid code SHALL go to RESP with resp_err=1 and SHALL leave control_signal unchanged.
REQ-019 Any command accepted while lock_on=1 SHALL be rejected like an invalid code, including 0011; the lock is released only by reset.
REQ-020 A valid code equal to the current control_signal SHALL go directly to RESP with resp_err=0 and no settle period.
REQ-021 Any other valid code SHALL go to APPLY; APPLY writes control_signal on that edge and enters SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a 4-bit down-counter, and then enter RESP with resp_err=0.
REQ-023 resp_valid SHALL be 1 only in RESP and SHALL hold its value, together with resp_err, until resp_ready=1; the FSM then returns to IDLE on that edge.
REQ-024 For an accept at edge N with a code change, control_signal SHALL update at edge N+1 and resp_valid SHALL rise at edge N+1+SETTLE_CYCLES.
REQ-025 For a rejected command or a no-op, resp_valid SHALL rise at edge N+1.
REQ-026 cmd_code SHALL be captured at accept, so changes to cmd_code after acceptance have no effect.
REQ-027 enable_all and lock_on SHALL be combinational decodes of the registered control_signal, so they add no latency.

Reset
REQ-028 While rst=1 the block SHALL set: state=IDLE, control_signal=0010, enable_all=0, lock_on=0, resp_valid=0, resp_err=0, busy=0, err_count=0 and settle counter=0.
REQ-029 rst asserted in any state, including mid-SETTLE, SHALL abort the operation and apply the REQ-028 values with no response issued.
REQ-030 cmd_ready SHALL be 1 on the first clock edge after rst deasserts.

Configuration
REQ-031 With macro CTRL_SEQ_ERR_CNT_EN defined, err_count SHALL increment by 1 on each rejected command and SHALL saturate at 255.
REQ-032 Without CTRL_SEQ_ERR_CNT_EN, err_count SHALL be tied to 0 and no counter logic is synthesised; all other behaviour is identical.

Structure
REQ-033 Package ctrl_seq_pkg SHALL hold:
- the state enum typedef;
- the code constants CODE_ENABLE=0001, CODE_DISABLE=0010 and CODE_LOCK=0011;
- the reset code constant;
- a code_is_valid function.
REQ-034 The decode to enable_all and lock_on SHALL be in sub-module ctrl_code_decode, with pure combinational outputs that are false/false for any code other than 0001 and 0011.

Verification
REQ-035 After reset, send cmd 0001 with SETTLE_CYCLES=4: control_signal=0001 one edge after accept, resp_valid rises 5 edges after accept, resp_err=0, enable_all=1.
REQ-036 Send cmd 0011 then cmd 0001: lock_on=1 after the first; the second gets resp_err=1, control_signal stays 0011, and err_count=1 when the macro is on (0 when off).
REQ-037 Send cmd 0111 and cmd 0000: each gets resp_valid one edge after accept with resp_err=1, and control_signal stays 0010.
REQ-038 Send cmd 0010 from the reset state: it is a no-op, with resp one edge after accept, resp_err=0 and no SETTLE entered.
REQ-039 Hold resp_ready=0 for 10 cycles: resp_valid and resp_err stay stable and cmd_ready=0 throughout; resp_ready=1 gives IDLE on the next edge.
REQ-040 Assert rst on the 2nd cycle of SETTLE after cmd 0011: immediately control_signal=0010, lock_on=0 and resp_valid=0; after release, cmd 0001 is accepted normally.
